// File: rtl/mig_read_unpacker.sv
// Read-side unpacker for the DDR4 MIG AXI4 path. It buffers 512-bit R beats and
// emits them MSB-first as a framed stream of 16*P-bit words, trimmed to the message length.
module mig_read_unpacker #(
   parameter int unsigned P = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             rvalid,
   input  logic [511:0]     rdata,
   input  logic             rlast,
   output logic             rready,
   input  logic             msgvalid,
   output logic             msgready,
   input  logic [15:0]      messagesize,
   output logic [16*P-1:0]  odata,
   output logic             ovalid,
   input  logic             oready,
   output logic             ostart,
   output logic             olast,
   output logic [3:0]       datacount,
   output logic             protoerr
);

   localparam int unsigned W      = 16 * P;
   localparam int unsigned WPB    = 32 / P;
   localparam int unsigned LOG2P  = $clog2(P);
   localparam int unsigned BEAT_W = 512;
   localparam int unsigned DEPTH  = 16;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [3:0]        wr_ptr_q, wr_ptr_d;
   logic [3:0]        rd_ptr_q, rd_ptr_d;
   logic [3:0]        count_q, count_d;
   logic [BEAT_W-1:0] mem_q [DEPTH];
   logic [BEAT_W-1:0] sh_q, sh_d;
   logic              sh_vld_q, sh_vld_d;
   logic [5:0]        widx_q, widx_d;
   logic [15:0]       n_q, n_d;
   logic [15:0]       b_q, b_d;
   logic [15:0]       wsent_q, wsent_d;
   logic [15:0]       consumed_q, consumed_d;
   logic [W-1:0]      odata_q, odata_d;
   logic              ovalid_q, ovalid_d;
   logic              ostart_q, ostart_d;
   logic              olast_q, olast_d;
   logic              rready_q, rready_d;
   logic              msgready_q, msgready_d;
   logic [2:0]        bcnt_q, bcnt_d;
   logic              protoerr_q, protoerr_d;

   logic              push, pop;
   logic [15:0]       msg_n;
   logic [8:0]        msg_bursts;
   logic [16:0]       msg_beats;
   logic [15:0]       msg_b;

   // Word count and the number of beats the DDR side returns for this message.
   assign msg_n      = messagesize >> LOG2P;
   assign msg_bursts = 9'((17'(messagesize) + 17'd255) >> 8);
   assign msg_beats  = {5'd0, msg_bursts, 3'b000};
   assign msg_b      = (msg_beats > 17'h0FFF8) ? 16'hFFF8 : msg_beats[15:0];

   assign push = rvalid && rready_q;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      sh_d       = sh_q;
      sh_vld_d   = sh_vld_q;
      widx_d     = widx_q;
      n_d        = n_q;
      b_d        = b_q;
      wsent_d    = wsent_q;
      consumed_d = consumed_q;
      odata_d    = odata_q;
      ovalid_d   = ovalid_q;
      ostart_d   = ostart_q;
      olast_d    = olast_q;
      bcnt_d     = bcnt_q;
      protoerr_d = protoerr_q;
      pop        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (msgvalid && (msg_n != 16'd0)) begin
               n_d        = msg_n;
               b_d        = msg_b;
               wsent_d    = 16'd0;
               consumed_d = 16'd0;
               state_d    = S_STREAM;
            end
         end
         S_STREAM: begin
            if (ovalid_q && oready && olast_q) begin
               ovalid_d = 1'b0;
               ostart_d = 1'b0;
               olast_d  = 1'b0;
               sh_vld_d = 1'b0;
               widx_d   = 6'd0;
               state_d  = S_DRAIN;
            end else begin
               if (!sh_vld_q && (count_q != 4'd0)) begin
                  sh_d     = mem_q[rd_ptr_q];
                  sh_vld_d = 1'b1;
               end
               if (!ovalid_q || oready) begin
                  if (sh_vld_q && (wsent_q != n_q)) begin
                     odata_d  = sh_q[BEAT_W-1 -: W];
                     ovalid_d = 1'b1;
                     ostart_d = (wsent_q == 16'd0);
                     olast_d  = (wsent_q == n_q - 16'd1);
                     wsent_d  = wsent_q + 16'd1;
                     sh_d     = sh_q << W;
                     // Last word of the beat: pop it and chain straight into the next one.
                     if (widx_q == 6'(WPB - 1)) begin
                        pop        = 1'b1;
                        consumed_d = consumed_q + 16'd1;
                        widx_d     = 6'd0;
                        if (count_q > 4'd1) begin
                           sh_d = mem_q[rd_ptr_q + 4'd1];
                        end else begin
                           sh_vld_d = 1'b0;
                        end
                     end else begin
                        widx_d = widx_q + 6'd1;
                     end
                  end else begin
                     ovalid_d = 1'b0;
                     ostart_d = 1'b0;
                     olast_d  = 1'b0;
                  end
               end
            end
         end
         S_DRAIN: begin
            sh_vld_d = 1'b0;
            if (consumed_q == b_q) begin
               state_d = S_IDLE;
            end else if (count_q != 4'd0) begin
               pop        = 1'b1;
               consumed_d = consumed_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (push) begin
         wr_ptr_d = wr_ptr_q + 4'd1;
         bcnt_d   = bcnt_q + 3'd1;
         if (rlast != (bcnt_q == 3'd7)) begin
            protoerr_d = 1'b1;
         end
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 4'd1;
      end
      if (push && !pop) begin
         count_d = count_q + 4'd1;
      end else if (!push && pop) begin
         count_d = count_q - 4'd1;
      end

      rready_d   = (state_d != S_IDLE) && (count_d != 4'd15);
      msgready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= 4'd0;
         rd_ptr_q   <= 4'd0;
         count_q    <= 4'd0;
         sh_q       <= '0;
         sh_vld_q   <= 1'b0;
         widx_q     <= 6'd0;
         n_q        <= 16'd0;
         b_q        <= 16'd0;
         wsent_q    <= 16'd0;
         consumed_q <= 16'd0;
         odata_q    <= '0;
         ovalid_q   <= 1'b0;
         ostart_q   <= 1'b0;
         olast_q    <= 1'b0;
         rready_q   <= 1'b0;
         msgready_q <= 1'b1;
         bcnt_q     <= 3'd0;
         protoerr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         sh_q       <= sh_d;
         sh_vld_q   <= sh_vld_d;
         widx_q     <= widx_d;
         n_q        <= n_d;
         b_q        <= b_d;
         wsent_q    <= wsent_d;
         consumed_q <= consumed_d;
         odata_q    <= odata_d;
         ovalid_q   <= ovalid_d;
         ostart_q   <= ostart_d;
         olast_q    <= olast_d;
         rready_q   <= rready_d;
         msgready_q <= msgready_d;
         bcnt_q     <= bcnt_d;
         protoerr_q <= protoerr_d;
      end
   end

   // Beat storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= rdata;
      end
   end

   assign rready    = rready_q;
   assign msgready  = msgready_q;
   assign odata     = odata_q;
   assign ovalid    = ovalid_q;
   assign ostart    = ostart_q;
   assign olast     = olast_q;
   assign datacount = count_q;
   assign protoerr  = protoerr_q;

endmodule
